// File: rtl/waveform_pingpong_ctrl.sv
// Ping-pong waveform buffer sequencer: packs 16-bit pipe words into samples,
// loads the inactive bank and plays the active bank. Banks swap only at a
// waveform wrap, or immediately from idle, once the inactive bank is full.
module waveform_pingpong_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              ti_clk,
    input  logic              reset,
    input  logic              feed_data_valid,
    input  logic [15:0]       feed_data,
    input  logic              flush,
    input  logic              play_en,
    input  logic              play_tick,
    input  logic              rewind,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              play_valid,
    output logic              wrap,
    output logic              load_done,
    output logic              overflow
);

    localparam int unsigned WORD_W = 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    localparam logic [0:0] L_LOAD = 1'b0;
    localparam logic [0:0] L_FULL = 1'b1;
    localparam logic [0:0] P_IDLE = 1'b0;
    localparam logic [0:0] P_RUN  = 1'b1;

    logic [0:0]        l_state, l_state_nx;
    logic [0:0]        p_state, p_state_nx;
    logic              phase_hi, phase_hi_nx;
    logic [WORD_W-1:0] lo_word, lo_word_nx;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nx;
    logic              active_bank, active_bank_nx;
    logic              swap;

    logic              wr_en_nx, wr_bank_nx, play_valid_nx, wrap_nx;
    logic              load_done_nx, overflow_nx;
    logic [ADDR_W-1:0] wr_addr_nx, rd_addr_nx;
    logic [DATA_W-1:0] wr_data_nx;

    // The read side always exposes the active bank straight from its flop
    assign rd_bank = active_bank;

    // Next-state and output decode for the playback and loader FSMs
    always_comb begin
        l_state_nx     = l_state;
        p_state_nx     = p_state;
        phase_hi_nx    = phase_hi;
        lo_word_nx     = lo_word;
        wr_ptr_nx      = wr_ptr;
        active_bank_nx = active_bank;
        swap           = 1'b0;
        wr_en_nx       = 1'b0;
        wr_bank_nx     = ~active_bank;
        wr_addr_nx     = wr_addr;
        wr_data_nx     = wr_data;
        rd_addr_nx     = rd_addr;
        play_valid_nx  = play_valid;
        wrap_nx        = 1'b0;
        load_done_nx   = load_done;
        overflow_nx    = overflow;

        // Playback: a flush in the same cycle cancels the pending swap
        case (p_state)
            P_IDLE: begin
                rd_addr_nx    = '0;
                play_valid_nx = 1'b0;
                if (load_done && !flush) begin
                    swap          = 1'b1;
                    p_state_nx    = P_RUN;
                    play_valid_nx = 1'b1;
                end
            end
            default: begin
                if (rewind) begin
                    rd_addr_nx = '0;
                end else if (play_tick && play_en) begin
                    if (rd_addr == LAST_ADDR) begin
                        rd_addr_nx = '0;
                        wrap_nx    = 1'b1;
                        swap       = load_done && !flush;
                    end else begin
                        rd_addr_nx = rd_addr + 1'b1;
                    end
                end
            end
        endcase

        if (swap) begin
            active_bank_nx = ~active_bank;
        end

        // Loader: flush wins over any word presented in the same cycle
        if (flush) begin
            l_state_nx   = L_LOAD;
            wr_ptr_nx    = '0;
            phase_hi_nx  = 1'b0;
            overflow_nx  = 1'b0;
            load_done_nx = 1'b0;
        end else begin
            case (l_state)
                L_LOAD: begin
                    if (feed_data_valid) begin
                        if (!phase_hi) begin
                            lo_word_nx  = feed_data;
                            phase_hi_nx = 1'b1;
                        end else begin
                            wr_en_nx    = 1'b1;
                            wr_addr_nx  = wr_ptr;
                            wr_data_nx  = DATA_W'({feed_data, lo_word});
                            wr_ptr_nx   = wr_ptr + 1'b1;
                            phase_hi_nx = 1'b0;
                            if (wr_ptr == LAST_ADDR) begin
                                l_state_nx   = L_FULL;
                                load_done_nx = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (feed_data_valid) begin
                        overflow_nx = 1'b1;
                    end
                    if (swap) begin
                        l_state_nx   = L_LOAD;
                        wr_ptr_nx    = '0;
                        phase_hi_nx  = 1'b0;
                        load_done_nx = 1'b0;
                    end
                end
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously on reset
    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            l_state     <= L_LOAD;
            p_state     <= P_IDLE;
            phase_hi    <= 1'b0;
            lo_word     <= '0;
            wr_ptr      <= '0;
            active_bank <= 1'b0;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_addr     <= '0;
            play_valid  <= 1'b0;
            wrap        <= 1'b0;
            load_done   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            l_state     <= l_state_nx;
            p_state     <= p_state_nx;
            phase_hi    <= phase_hi_nx;
            lo_word     <= lo_word_nx;
            wr_ptr      <= wr_ptr_nx;
            active_bank <= active_bank_nx;
            wr_en       <= wr_en_nx;
            wr_bank     <= wr_bank_nx;
            wr_addr     <= wr_addr_nx;
            wr_data     <= wr_data_nx;
            rd_addr     <= rd_addr_nx;
            play_valid  <= play_valid_nx;
            wrap        <= wrap_nx;
            load_done   <= load_done_nx;
            overflow    <= overflow_nx;
        end
    end

endmodule
